xalu_ctrl: RTL and testbench

Sequencer for the multi-cycle multiply/divide unit (XALU) and owner of the HI/LO architectural registers. It accepts one operation per issue from the execute stage and runs multiplies in a fixed-latency pipeline. Divides run on a 1-bit-per-cycle restoring divider, and multiply-accumulate ops get an extra accumulate cycle. Its `busy` output feeds the decode-stage hazard logic, which stalls every HI/LO-family instruction while an operation is in flight.

---
 rtl/xalu_ctrl_if.sv | 16 +
 rtl/xalu_ctrl.sv | 116 +++++++++++
 tb/tb_xalu_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/xalu_ctrl_if.sv
// xalu_ctrl_if: issue/result bundle between the execute stage and the XALU sequencer
// master (execute stage) drives start/op/a/b/flush; slave (xalu_ctrl) drives busy/hi/lo/mul_valid/mul_res
interface xalu_ctrl_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_valid;
  logic [31:0] mul_res;
  modport master (output start, op, a, b, flush, input busy, hi, lo, mul_valid, mul_res);
  modport slave (input start, op, a, b, flush, output busy, hi, lo, mul_valid, mul_res);
endinterface

// File: rtl/xalu_ctrl.sv
// xalu_ctrl: multiply/divide sequencer owning the HI/LO registers
// Ports: clk, resetn (async active-low), bus (xalu_ctrl_if.slave: start/op/a/b/flush in,
// busy/hi/lo/mul_valid/mul_res out). MUL_CYCLES sets multiplier latency (1..8).
// Optional macro XALU_EARLY_DIV_EN: divides with |b|=0 or |a|<|b| finish after one DIV cycle.
module xalu_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input logic        clk,
  input logic        resetn,
  xalu_ctrl_if.slave bus
);
  localparam logic [3:0] OP_MULT = 4'd0, OP_MULTU = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3,
                         OP_MTHI = 4'd4, OP_MTLO = 4'd5, OP_MADD = 4'd6,
                         OP_MSUB = 4'd8, OP_MSUBU = 4'd9, OP_MUL = 4'd10;
  localparam logic [2:0] MC = 3'(MUL_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, MUL, ACC, DIV, FIX} state_t;
  state_t      state;
  logic [3:0]  opc;
  logic [31:0] opa, opb, quo, rem, dvs, hi, lo, mul_res, abs_a, abs_b;
  logic [2:0]  mcnt;
  logic [4:0]  dcnt;
  logic        neg_q, neg_r, mul_valid, sgn_mul, sgn_div, early, ge;
  logic [63:0] prod, acc;
  logic [32:0] shifted, diff;
  assign bus.busy      = state != IDLE;
  assign bus.hi        = hi;
  assign bus.lo        = lo;
  assign bus.mul_valid = mul_valid;
  assign bus.mul_res   = mul_res;
  always_comb begin
    sgn_mul = opc == OP_MULT || opc == OP_MADD || opc == OP_MSUB || opc == OP_MUL;
    prod    = {{32{sgn_mul & opa[31]}}, opa} * {{32{sgn_mul & opb[31]}}, opb};
    acc     = (opc == OP_MSUB || opc == OP_MSUBU) ? {hi, lo} - prod : {hi, lo} + prod;
    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dvs};
    ge      = !diff[32];
    sgn_div = bus.op == OP_DIV;
    abs_a   = (sgn_div && bus.a[31]) ? -bus.a : bus.a;
    abs_b   = (sgn_div && bus.b[31]) ? -bus.b : bus.b;
  end
`ifdef XALU_EARLY_DIV_EN
  assign early = dcnt == 5'd31 && (dvs == '0 || quo < dvs);
`else
  assign early = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      opc       <= '0;
      opa       <= '0;
      opb       <= '0;
      mcnt      <= '0;
      dcnt      <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      mul_valid <= 1'b0;
      mul_res   <= '0;
    end else begin
      mul_valid <= 1'b0;
      if (state != IDLE && bus.flush) state <= IDLE;
      else case (state)
        IDLE: if (bus.start && !bus.flush && bus.op <= OP_MUL) begin
          opc   <= bus.op;
          opa   <= bus.a;
          opb   <= bus.b;
          mcnt  <= MC;
          dcnt  <= 5'd31;
          rem   <= '0;
          quo   <= abs_a;
          dvs   <= abs_b;
          neg_q <= sgn_div && (bus.a[31] ^ bus.b[31]);
          neg_r <= sgn_div && bus.a[31];
          if (bus.op == OP_MTHI) hi <= bus.a;
          else if (bus.op == OP_MTLO) lo <= bus.a;
          else state <= (bus.op == OP_DIV || bus.op == OP_DIVU) ? DIV : MUL;
        end
        MUL: if (mcnt == '0) begin
          if (opc == OP_MUL) begin
            mul_valid <= 1'b1;
            mul_res   <= prod[31:0];
            state     <= IDLE;
          end else if (opc == OP_MULT || opc == OP_MULTU) begin
            {hi, lo} <= prod;
            state    <= IDLE;
          end else state <= ACC;
        end else mcnt <= mcnt - 3'd1;
        ACC: begin
          {hi, lo} <= acc;
          state    <= IDLE;
        end
        DIV: if (early) begin
          quo   <= (dvs == '0) ? '1 : '0;
          rem   <= quo;
          state <= FIX;
        end else begin
          quo  <= {quo[30:0], ge};
          rem  <= ge ? diff[31:0] : shifted[31:0];
          dcnt <= dcnt - 5'd1;
          if (dcnt == '0) state <= FIX;
        end
        FIX: begin
          lo    <= neg_q ? -quo : quo;
          hi    <= neg_r ? -rem : rem;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xalu_ctrl.sv
// tb_xalu_ctrl: directed self-checking bench for xalu_ctrl (MUL_CYCLES=3)
module tb_xalu_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
`ifdef XALU_EARLY_DIV_EN
  localparam int SHORT_DIV = 2;
`else
  localparam int SHORT_DIV = 33;
`endif
  xalu_ctrl_if bus ();
  xalu_ctrl #(.MUL_CYCLES(3)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic busy_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 64'(bus.busy), 64'd1);
      tick();
    end
    chk(tag, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    tick(2);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mulv", 64'(bus.mul_valid), 64'd0);
    chk("rst_mulres", 64'(bus.mul_res), 64'd0);
    resetn = 1'b1;
    tick();
    issue(4'd0, 32'hFFFFFFFF, 32'h00000002);
    busy_for("mult_busy", 3);
    chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(4'd2, 32'hFFFFFFF9, 32'h00000002);
    busy_for("div_busy", 33);
    chk("div_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(4'd5, 32'hFFFFFFFF, 32'h0);
    chk("mtlo", 64'(bus.lo), 64'hFFFFFFFF);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    issue(4'd4, 32'h00000000, 32'h0);
    chk("mthi", 64'(bus.hi), 64'h0);
    issue(4'd7, 32'd1, 32'd1);
    busy_for("maddu_busy", 4);
    chk("maddu_hilo", {bus.hi, bus.lo}, 64'h00000001_00000000);
    issue(4'd4, 32'h11, 32'h0);
    issue(4'd5, 32'h22, 32'h0);
    issue(4'd3, 32'd100, 32'd7);
    tick(9);
    chk("flush_busy_pre", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h00000011_00000022);
    tick(30);
    chk("flush_hilo_late", {bus.hi, bus.lo}, 64'h00000011_00000022);
    issue(4'd10, 32'h00010000, 32'h00010001);
    chk("mul_v_t1", 64'(bus.mul_valid), 64'd0);
    tick();
    issue(4'd4, 32'hDEADBEEF, 32'h0);
    chk("mul_ign_hi", 64'(bus.hi), 64'h11);
    chk("mul_v_t3", 64'(bus.mul_valid), 64'd0);
    tick();
    chk("mul_v_t4", 64'(bus.mul_valid), 64'd1);
    chk("mul_res", 64'(bus.mul_res), 64'h00010000);
    chk("mul_busy", 64'(bus.busy), 64'd0);
    chk("mul_hilo", {bus.hi, bus.lo}, 64'h00000011_00000022);
    tick();
    chk("mul_v_t5", 64'(bus.mul_valid), 64'd0);
    issue(4'd3, 32'd5, 32'd0);
    busy_for("divu0_busy", SHORT_DIV);
    chk("divu0_hilo", {bus.hi, bus.lo}, 64'h00000005_FFFFFFFF);
    issue(4'd2, 32'hFFFFFFFB, 32'd0);
    busy_for("div0s_busy", SHORT_DIV);
    chk("div0s_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFB_00000001);
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    busy_for("divovf_busy", 33);
    chk("divovf_hilo", {bus.hi, bus.lo}, 64'h00000000_80000000);
    issue(4'd3, 32'd3, 32'd10);
    busy_for("divu_small_busy", SHORT_DIV);
    chk("divu_small_hilo", {bus.hi, bus.lo}, 64'h00000003_00000000);
    issue(4'd4, 32'h0, 32'h0);
    issue(4'd5, 32'h0, 32'h0);
    issue(4'd8, 32'd2, 32'd3);
    busy_for("msub_busy", 4);
    chk("msub_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(4'd11, 32'h1234, 32'h0);
    chk("illegal_busy", 64'(bus.busy), 64'd0);
    chk("illegal_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(4'd1, 32'hFFFFFFFF, 32'h2);
    chk("arst_busy_pre", 64'(bus.busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
